// File: rtl/nw_fill_controller_pkg.sv
// Shared definitions for the Needleman-Wunsch fill controller:
// score type, symbol and direction codes, FSM encodings, saturation.
package nw_fill_controller_pkg;

    localparam int SCORE_W = 9;

    typedef logic signed [SCORE_W-1:0] score_t;
    typedef logic signed [SCORE_W:0]   wide_t;

    localparam logic [1:0] NUC_A = 2'd0;
    localparam logic [1:0] NUC_C = 2'd1;
    localparam logic [1:0] NUC_G = 2'd2;
    localparam logic [1:0] NUC_T = 2'd3;

    localparam logic [1:0] DIR_DIAG = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_LEFT = 2'b10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_CALC  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_ADV   = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    localparam wide_t SAT_MAX = 10'sd255;
    localparam wide_t SAT_MIN = -10'sd256;

    function automatic score_t sat(input wide_t v);
        if (v > SAT_MAX) begin
            return SAT_MAX[SCORE_W-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[SCORE_W-1:0];
        end
        return v[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/nw_cell_max.sv
// Combinational cell scorer: diag/up/left candidates,
// widened adds, clamp to score range, pick winner.
module nw_cell_max
    import nw_fill_controller_pkg::*;
#(
    parameter score_t MATCH    = 9'sd1,
    parameter score_t MISMATCH = -9'sd1,
    parameter score_t GAP      = -9'sd2
) (
    input  score_t     diag,
    input  score_t     up,
    input  score_t     left,
    input  logic [1:0] char_a,
    input  logic [1:0] char_b,
    output score_t     max,
    output logic [1:0] dir
);

    score_t bonus;
    wide_t  d_sum;
    wide_t  u_sum;
    wide_t  l_sum;
    score_t d_sat;
    score_t u_sat;
    score_t l_sat;

    // Candidate scores; ties resolve diag, then up, then left.
    always_comb begin
        bonus = (char_a == char_b) ? MATCH : MISMATCH;
        d_sum = {diag[SCORE_W-1], diag} + {bonus[SCORE_W-1], bonus};
        u_sum = {up[SCORE_W-1], up} + {GAP[SCORE_W-1], GAP};
        l_sum = {left[SCORE_W-1], left} + {GAP[SCORE_W-1], GAP};
        d_sat = sat(d_sum);
        u_sat = sat(u_sum);
        l_sat = sat(l_sum);
        if (d_sat >= u_sat && d_sat >= l_sat) begin
            max = d_sat;
            dir = DIR_DIAG;
        end else if (u_sat >= l_sat) begin
            max = u_sat;
            dir = DIR_UP;
        end else begin
            max = l_sat;
            dir = DIR_LEFT;
        end
    end

endmodule

// File: rtl/nw_fill_controller.sv
// Needleman-Wunsch matrix fill sequencer: gap init of row/col 0,
// then row-major cell walk with read/calc/write/advance per cell.
module nw_fill_controller
    import nw_fill_controller_pkg::*;
#(
    parameter int     N        = 128,
    parameter int     BitAddr  = $clog2(N + 1),
    parameter score_t MATCH    = 9'sd1,
    parameter score_t MISMATCH = -9'sd1,
    parameter score_t GAP      = -9'sd2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       char_a,
    input  logic [1:0]       char_b,
    input  logic             signal,
    input  score_t           diag,
    input  score_t           up,
    input  score_t           left,
    output logic [BitAddr:0] i,
    output logic [BitAddr:0] j,
    output logic [BitAddr:0] addr_init,
    output score_t           data_init,
    output logic             en_init,
    output logic             en_ins,
    output logic             we,
    output logic             en_read,
    output logic             change_index,
    output score_t           max,
    output logic [1:0]       dir,
    output logic             dir_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [BitAddr:0] LAST = (BitAddr + 1)'(N);
    localparam logic [BitAddr:0] ONE  = (BitAddr + 1)'(1);

    logic [2:0]       state;
    logic [BitAddr:0] k;
    logic             half;
    score_t           diag_q;
    score_t           up_q;
    score_t           left_q;
    score_t           cell_max;
    logic [1:0]       cell_dir;

    nw_cell_max #(
        .MATCH    (MATCH),
        .MISMATCH (MISMATCH),
        .GAP      (GAP)
    ) u_cell (
        .diag   (diag_q),
        .up     (up_q),
        .left   (left_q),
        .char_a (char_a),
        .char_b (char_b),
        .max    (cell_max),
        .dir    (cell_dir)
    );

    // FSM, init counter (two writes per k), cell indices, result regs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            k      <= '0;
            half   <= 1'b0;
            i      <= '0;
            j      <= '0;
            diag_q <= '0;
            up_q   <= '0;
            left_q <= '0;
            max    <= '0;
            dir    <= DIR_DIAG;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_INIT;
                        k     <= '0;
                        half  <= 1'b0;
                        i     <= '0;
                        j     <= '0;
                    end
                end
                ST_INIT: begin
                    half <= ~half;
                    if (half) begin
                        if (k == LAST) begin
                            i     <= ONE;
                            j     <= ONE;
                            state <= ST_READ;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (signal) begin
                        diag_q <= diag;
                        up_q   <= up;
                        left_q <= left;
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    max   <= cell_max;
                    dir   <= cell_dir;
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    state <= ST_ADV;
                end
                ST_ADV: begin
                    if (j != LAST) begin
                        j     <= j + 1'b1;
                        state <= ST_READ;
                    end else if (i != LAST) begin
                        j     <= ONE;
                        i     <= i + 1'b1;
                        state <= ST_READ;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from state so reset clears them at once.
    always_comb begin
        en_init      = (state == ST_INIT);
        en_ins       = (state == ST_WRITE);
        we           = (state == ST_INIT) || (state == ST_WRITE);
        en_read      = (state == ST_READ);
        change_index = (state == ST_ADV);
        dir_valid    = (state == ST_WRITE);
        done         = (state == ST_DONE);
        busy         = (state == ST_INIT) || (state == ST_READ) ||
                       (state == ST_CALC) || (state == ST_WRITE) ||
                       (state == ST_ADV);
        addr_init    = '0;
        data_init    = '0;
        if (state == ST_INIT) begin
            addr_init = k;
            data_init = SCORE_W'(int'(GAP) * int'(k));
        end
    end

endmodule

// File: tb/tb_nw_fill_controller.sv
// Directed bench for nw_fill_controller (N=4): reset, init,
// cell-score vector table, full ACGT/ACGT runs with restart.
module tb_nw_fill_controller;
    import nw_fill_controller_pkg::*;

    localparam int NN = 4;
    localparam int BA = $clog2(NN + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    char_a = '0;
    logic [1:0]    char_b = '0;
    logic          signal = 1'b0;
    score_t        diag = '0;
    score_t        up = '0;
    score_t        left = '0;
    logic [BA:0]   i;
    logic [BA:0]   j;
    logic [BA:0]   addr_init;
    score_t        data_init;
    logic          en_init;
    logic          en_ins;
    logic          we;
    logic          en_read;
    logic          change_index;
    score_t        max;
    logic [1:0]    dir;
    logic          dir_valid;
    logic          busy;
    logic          done;

    int n_chk = 0;
    int n_fail = 0;
    int pulses = 0;

    score_t     ram [0:NN][0:NN];
    int         refm [0:NN][0:NN];
    logic [1:0] rdir [0:NN][0:NN];
    logic [1:0] seq [0:NN-1];

    typedef struct {
        score_t     d;
        score_t     u;
        score_t     l;
        logic [1:0] ca;
        logic [1:0] cb;
        int         emax;
        logic [1:0] edir;
    } vec_t;

    vec_t vecs [0:9];

    nw_fill_controller #(.N(NN)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .char_a       (char_a),
        .char_b       (char_b),
        .signal       (signal),
        .diag         (diag),
        .up           (up),
        .left         (left),
        .i            (i),
        .j            (j),
        .addr_init    (addr_init),
        .data_init    (data_init),
        .en_init      (en_init),
        .en_ins       (en_ins),
        .we           (we),
        .en_read      (en_read),
        .change_index (change_index),
        .max          (max),
        .dir          (dir),
        .dir_valid    (dir_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Behavioural score RAM: captures init and cell writes.
    always @(posedge clk) begin
        if (en_init) begin
            ram[addr_init][0] = data_init;
            ram[0][addr_init] = data_init;
        end
        if (en_ins) ram[i][j] = max;
        if (dir_valid) pulses = pulses + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input integer act, input integer exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " flags"},
            {en_init, en_ins, we, en_read, change_index,
             dir_valid, busy, done, dir}, 0);
        chk({nm, " idx"}, {i, j, addr_init}, 0);
        chk({nm, " data_init"}, data_init, 0);
        chk({nm, " max"}, max, 0);
    endtask

    task automatic serve(input score_t d, input score_t u, input score_t l,
                         input logic [1:0] ca, input logic [1:0] cb,
                         input int ei, input int ej,
                         input integer emax, input logic [1:0] edir);
        int n;
        n = 0;
        while (en_read !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk($sformatf("cell(%0d,%0d) en_read", ei, ej), en_read, 1);
        if (en_read !== 1'b1) return;
        chk($sformatf("cell(%0d,%0d) i", ei, ej), i, ei);
        chk($sformatf("cell(%0d,%0d) j", ei, ej), j, ej);
        char_a = ca;
        char_b = cb;
        tick();
        tick();
        diag = d;
        up = u;
        left = l;
        signal = 1'b1;
        tick();
        signal = 1'b0;
        n = 0;
        while (dir_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk($sformatf("cell(%0d,%0d) dir_valid", ei, ej), dir_valid, 1);
        if (dir_valid !== 1'b1) return;
        chk($sformatf("cell(%0d,%0d) en_ins", ei, ej), {en_ins, we}, 3);
        chk($sformatf("cell(%0d,%0d) max", ei, ej), max, emax);
        chk($sformatf("cell(%0d,%0d) dir", ei, ej), dir, edir);
        tick();
        chk($sformatf("cell(%0d,%0d) change_index", ei, ej), change_index, 1);
    endtask

    task automatic full_run(input string tag);
        int p0;
        p0 = pulses;
        for (int ii = 1; ii <= NN; ii++) begin
            for (int jj = 1; jj <= NN; jj++) begin
                serve(ram[ii-1][jj-1], ram[ii-1][jj], ram[ii][jj-1],
                      seq[ii-1], seq[jj-1], ii, jj,
                      refm[ii][jj], rdir[ii][jj]);
            end
        end
        tick();
        chk({tag, " pulses"}, pulses - p0, 16);
        chk({tag, " done"}, done, 1);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " i"}, i, NN);
        chk({tag, " j"}, j, NN);
        chk({tag, " last max"}, max, 4);
    endtask

    task automatic build_ref();
        int d;
        int u;
        int l;
        seq[0] = NUC_A;
        seq[1] = NUC_C;
        seq[2] = NUC_G;
        seq[3] = NUC_T;
        for (int k = 0; k <= NN; k++) begin
            refm[k][0] = -2 * k;
            refm[0][k] = -2 * k;
        end
        for (int ii = 1; ii <= NN; ii++) begin
            for (int jj = 1; jj <= NN; jj++) begin
                d = refm[ii-1][jj-1] + ((seq[ii-1] == seq[jj-1]) ? 1 : -1);
                u = refm[ii-1][jj] - 2;
                l = refm[ii][jj-1] - 2;
                if (d >= u && d >= l) begin
                    refm[ii][jj] = d;
                    rdir[ii][jj] = DIR_DIAG;
                end else if (u >= l) begin
                    refm[ii][jj] = u;
                    rdir[ii][jj] = DIR_UP;
                end else begin
                    refm[ii][jj] = l;
                    rdir[ii][jj] = DIR_LEFT;
                end
            end
        end
    endtask

    initial begin
        vecs[0] = '{9'sd0, -9'sd2, -9'sd2, NUC_A, NUC_A, 1, DIR_DIAG};
        vecs[1] = '{9'sd0, -9'sd2, -9'sd2, NUC_A, NUC_C, -1, DIR_DIAG};
        vecs[2] = '{-9'sd1, 9'sd0, 9'sd0, NUC_A, NUC_C, -2, DIR_DIAG};
        vecs[3] = '{-9'sd5, 9'sd0, 9'sd0, NUC_A, NUC_A, -2, DIR_UP};
        vecs[4] = '{9'sd255, 9'sd0, 9'sd0, NUC_G, NUC_G, 255, DIR_DIAG};
        vecs[5] = '{-9'sd256, -9'sd256, -9'sd256, NUC_A, NUC_C, -256, DIR_DIAG};
        vecs[6] = '{9'sd0, 9'sd0, 9'sd10, NUC_T, NUC_A, 8, DIR_LEFT};
        vecs[7] = '{9'sd0, 9'sd20, 9'sd3, NUC_C, NUC_C, 18, DIR_UP};
        vecs[8] = '{-9'sd10, 9'sd5, 9'sd5, NUC_A, NUC_G, 3, DIR_UP};
        vecs[9] = '{-9'sd256, -9'sd256, -9'sd256, NUC_T, NUC_T, -255, DIR_DIAG};
        build_ref();

        #12;
        chk_zero("por");
        tick();
        rst = 1'b1;
        tick();
        chk_zero("idle");

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("init busy", busy, 1);
        for (int k = 0; k <= NN; k++) begin
            for (int h = 0; h < 2; h++) begin
                chk($sformatf("init k%0d h%0d en", k, h), {en_init, we}, 3);
                chk($sformatf("init k%0d h%0d addr", k, h), addr_init, k);
                chk($sformatf("init k%0d h%0d data", k, h), data_init, -2 * k);
                tick();
            end
        end
        chk("post-init en_init", en_init, 0);
        chk("post-init en_read", en_read, 1);

        for (int v = 0; v < 10; v++) begin
            serve(vecs[v].d, vecs[v].u, vecs[v].l, vecs[v].ca, vecs[v].cb,
                  1 + v / 4, 1 + v % 4, vecs[v].emax, vecs[v].edir);
        end

        rst = 1'b0;
        #1;
        chk_zero("reset mid-cell");
        tick();
        rst = 1'b1;
        tick();

        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre-reset en_init", en_init, 1);
        #2;
        rst = 1'b0;
        #1;
        chk_zero("reset mid-init");
        tick();
        rst = 1'b1;
        tick();
        chk_zero("idle after reset");

        start = 1'b1;
        tick();
        start = 1'b0;
        full_run("run1");

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart done clr", done, 0);
        chk("restart en_init", en_init, 1);
        chk("restart addr", addr_init, 0);
        for (int t = 0; t < 4; t++) tick();
        start = 1'b1;
        signal = 1'b1;
        tick();
        start = 1'b0;
        signal = 1'b0;
        chk("start ignored addr", addr_init, 2);
        chk("signal ignored", en_init, 1);
        full_run("run2");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
